// File: rtl/spi_slave_if_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if_if
// Bundles the SPI pins and the byte-side handshake of the SPI slave front end.
//   sclk, mosi, ss   : SPI pins (ss active-low), driven by the SPI master side
//   tx_data          : byte to serialise onto miso, supplied by the grid
//   miso             : SPI data out (idle-high while deselected)
//   rx_data, rx_done : received byte and its one-clk strobe
//   frame_active     : high while a frame is being served
// Modports: master = pin/tx driver side, slave = the SPI front end itself.
// -----------------------------------------------------------------------------
interface spi_slave_if_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  sclk;
   logic                  mosi;
   logic                  ss;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  miso;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_done;
   logic                  frame_active;

   modport master (
      output sclk, mosi, ss, tx_data,
      input  miso, rx_data, rx_done, frame_active
   );

   modport slave (
      input  sclk, mosi, ss, tx_data,
      output miso, rx_data, rx_done, frame_active
   );
endinterface

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// SPI mode-0 slave front end. Oversamples sclk/mosi/ss with clk, deserialises
// MOSI (MSB first) into bytes delivered with a one-clk rx_done strobe, and
// serialises tx_data onto MISO, changing MISO on sclk falling edges.
// Ports:
//   clk  : system clock, at least 4x the sclk frequency
//   rst  : asynchronous active-low reset
//   bus  : spi_slave_if_if.slave (sclk, mosi, ss, tx_data in;
//          miso, rx_data, rx_done, frame_active out)
// -----------------------------------------------------------------------------
module spi_slave_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   spi_slave_if_if.slave  bus
);
   localparam int                CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

   // Synchroniser chains and edge-detect delay flops
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic                   sclk_dly_q;
   logic                   ss_dly_q;
   // Fills with ones after reset; its top bit says the chains hold real samples
   logic [SYNC_STAGES:0]   flush_q;

   logic sclk_s, mosi_s, ss_s;
   logic rise_s, fall_s, ss_fall_s, flush_done_s;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [DATA_WIDTH-1:0] rx_next_s;
   logic                  rx_done_q, rx_done_d;
   logic                  miso_q, miso_d;
   logic                  frame_active_q, frame_active_d;
   // Armed once ss has been seen high after reset, so a frame already in
   // progress when reset releases is ignored until ss cycles high then low.
   logic                  arm_q, arm_d;

   assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s         = ss_sync_q[SYNC_STAGES-1];
   assign rise_s       = sclk_s & ~sclk_dly_q;
   assign fall_s       = ~sclk_s & sclk_dly_q;
   assign ss_fall_s    = ~ss_s & ss_dly_q;
   assign flush_done_s = flush_q[SYNC_STAGES];
   assign rx_next_s    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

   // Pin synchronisers, edge-detect delay flops and post-reset flush tracker
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_q <= {SYNC_STAGES{1'b0}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         ss_sync_q   <= {SYNC_STAGES{1'b1}};
         sclk_dly_q  <= 1'b0;
         ss_dly_q    <= 1'b1;
         flush_q     <= {(SYNC_STAGES+1){1'b0}};
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss};
         sclk_dly_q  <= sclk_s;
         ss_dly_q    <= ss_s;
         flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Frame state, shift registers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= CNT_ZERO;
         rx_shift_q     <= {DATA_WIDTH{1'b0}};
         tx_shift_q     <= {DATA_WIDTH{1'b1}};
         rx_data_q      <= {DATA_WIDTH{1'b0}};
         rx_done_q      <= 1'b0;
         miso_q         <= 1'b1;
         frame_active_q <= 1'b0;
         arm_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         rx_shift_q     <= rx_shift_d;
         tx_shift_q     <= tx_shift_d;
         rx_data_q      <= rx_data_d;
         rx_done_q      <= rx_done_d;
         miso_q         <= miso_d;
         frame_active_q <= frame_active_d;
         arm_q          <= arm_d;
      end
   end

   // Next-state logic: frame entry/exit, bit shifting and byte completion
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      rx_data_d  = rx_data_q;
      rx_done_d  = 1'b0;

      if (flush_done_s && ss_s && ss_dly_q) begin
         arm_d = 1'b1;
      end else begin
         arm_d = arm_q;
      end

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d  = CNT_ZERO;
            rx_shift_d = {DATA_WIDTH{1'b0}};
            if (ss_fall_s && arm_q) begin
               tx_shift_d = bus.tx_data;
               state_d    = ST_ACTIVE;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (rise_s) begin
               rx_shift_d = rx_next_s;
               if (bit_cnt_q == CNT_LAST) begin
                  rx_data_d = rx_next_s;
                  rx_done_d = 1'b1;
                  bit_cnt_d = CNT_ZERO;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
               end
            end else if (fall_s) begin
               // bit_cnt of zero on a fall means a byte boundary: reload
               if (bit_cnt_q == CNT_ZERO) begin
                  tx_shift_d = bus.tx_data;
               end else begin
                  tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b1};
               end
            end else begin
               tx_shift_d = tx_shift_q;
            end
            // Deselect is applied after any same-cycle rise has been taken
            if (ss_s) begin
               state_d    = ST_IDLE;
               bit_cnt_d  = CNT_ZERO;
               rx_shift_d = {DATA_WIDTH{1'b0}};
            end else begin
               state_d    = ST_ACTIVE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            bit_cnt_d  = CNT_ZERO;
            rx_shift_d = {DATA_WIDTH{1'b0}};
         end
      endcase

      // Outputs registered from next state so MISO tracks tx_shift without lag
      miso_d         = (state_d == ST_ACTIVE) ? tx_shift_d[DATA_WIDTH-1] : 1'b1;
      frame_active_d = (state_d == ST_ACTIVE);
   end

   assign bus.miso         = miso_q;
   assign bus.rx_data      = rx_data_q;
   assign bus.rx_done      = rx_done_q;
   assign bus.frame_active = frame_active_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_if
// Directed bench for spi_slave_if: acts as SPI master on the interface,
// logs every rx_done strobe with its rx_data, and checks against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;
   logic clk;
   logic rst;

   spi_slave_if_if #(.DATA_WIDTH(8)) bus ();

   spi_slave_if #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;
   int dbl_cnt  = 0;
   logic       prev_done = 1'b0;
   logic [7:0] rx_log [0:31];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log each rx_done strobe and flag back-to-back strobes
   always @(negedge clk) begin
      if (bus.rx_done === 1'b1) begin
         if (done_cnt < 32) rx_log[done_cnt] <= bus.rx_data;
         done_cnt <= done_cnt + 1;
         if (prev_done === 1'b1) dbl_cnt <= dbl_cnt + 1;
      end
      prev_done <= bus.rx_done;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shift nbits of mo MSB first; sample miso just before each rising sclk
   task automatic spi_byte(input logic [7:0] mo, input int half, input int nbits,
                           output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = mo[7-i];
         wait_clk(half);
         mi[7-i]  = bus.miso;
         bus.sclk = 1'b1;
         wait_clk(half);
         bus.sclk = 1'b0;
      end
   endtask

   logic [7:0] m1, m2, m3;
   int         base;

   initial begin
      // Reset with random pins
      rst          = 1'b0;
      bus.sclk     = 1'($urandom_range(1, 0));
      bus.mosi     = 1'($urandom_range(1, 0));
      bus.ss       = 1'($urandom_range(1, 0));
      bus.tx_data  = 8'($urandom_range(255, 0));
      wait_clk(4);
      chk("rst_miso", {31'd0, bus.miso}, 32'd1);
      chk("rst_rx_data", {24'd0, bus.rx_data}, 32'h00);
      chk("rst_rx_done", {31'd0, bus.rx_done}, 32'd0);
      chk("rst_frame_active", {31'd0, bus.frame_active}, 32'd0);
      bus.ss   = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      wait_clk(2);
      rst = 1'b1;
      wait_clk(10);
      chk("rel_miso", {31'd0, bus.miso}, 32'd1);
      chk("rel_rx_data", {24'd0, bus.rx_data}, 32'h00);
      chk("rel_frame_active", {31'd0, bus.frame_active}, 32'd0);
      chk("rel_no_done", done_cnt, 32'd0);

      // Single byte 0xA5 in, 0x3C out at clk/8
      bus.tx_data = 8'h3C;
      base = done_cnt;
      bus.ss = 1'b0;
      wait_clk(4);
      chk("single_frame_active", {31'd0, bus.frame_active}, 32'd1);
      chk("single_miso_first", {31'd0, bus.miso}, 32'd0);
      spi_byte(8'hA5, 4, 8, m1);
      bus.ss = 1'b1;
      wait_clk(6);
      chk("single_done_cnt", done_cnt - base, 32'd1);
      chk("single_rx_pulse", {24'd0, rx_log[base]}, 32'hA5);
      chk("single_miso_byte", {24'd0, m1}, 32'h3C);
      chk("single_frame_end", {31'd0, bus.frame_active}, 32'd0);
      chk("single_miso_idle", {31'd0, bus.miso}, 32'd1);

      // Abort after 5 bits of 0xF0
      base = done_cnt;
      bus.ss = 1'b0;
      wait_clk(4);
      spi_byte(8'hF0, 4, 5, m1);
      bus.ss = 1'b1;
      wait_clk(10);
      chk("abort_no_done", done_cnt - base, 32'd0);
      chk("abort_rx_data", {24'd0, bus.rx_data}, 32'hA5);
      bus.ss = 1'b0;
      wait_clk(4);
      spi_byte(8'h5A, 4, 8, m1);
      bus.ss = 1'b1;
      wait_clk(6);
      chk("after_abort_done_cnt", done_cnt - base, 32'd1);
      chk("after_abort_rx_data", {24'd0, bus.rx_data}, 32'h5A);

      // Back-to-back 0x01,0x80,0xFF; tx_data 0x11 -> 0x22 during byte 1
      bus.tx_data = 8'h11;
      base = done_cnt;
      bus.ss = 1'b0;
      wait_clk(4);
      fork
         spi_byte(8'h01, 4, 8, m1);
         begin
            wait_clk(20);
            bus.tx_data = 8'h22;
         end
      join
      spi_byte(8'h80, 4, 8, m2);
      spi_byte(8'hFF, 4, 8, m3);
      bus.ss = 1'b1;
      wait_clk(6);
      chk("b2b_done_cnt", done_cnt - base, 32'd3);
      chk("b2b_rx0", {24'd0, rx_log[base]}, 32'h01);
      chk("b2b_rx1", {24'd0, rx_log[base+1]}, 32'h80);
      chk("b2b_rx2", {24'd0, rx_log[base+2]}, 32'hFF);
      chk("b2b_miso0", {24'd0, m1}, 32'h11);
      chk("b2b_miso1", {24'd0, m2}, 32'h22);
      chk("b2b_miso2", {24'd0, m3}, 32'h22);

      // Reset mid-frame after 3 bits, ss kept low afterwards
      bus.tx_data = 8'h96;
      base = done_cnt;
      bus.ss = 1'b0;
      wait_clk(4);
      spi_byte(8'hC3, 4, 3, m1);
      rst = 1'b0;
      wait_clk(3);
      chk("midrst_miso", {31'd0, bus.miso}, 32'd1);
      chk("midrst_rx_data", {24'd0, bus.rx_data}, 32'h00);
      chk("midrst_rx_done", {31'd0, bus.rx_done}, 32'd0);
      chk("midrst_frame_active", {31'd0, bus.frame_active}, 32'd0);
      rst = 1'b1;
      wait_clk(4);
      spi_byte(8'hC3, 4, 8, m1);
      wait_clk(6);
      chk("ignored_no_done", done_cnt - base, 32'd0);
      chk("ignored_rx_data", {24'd0, bus.rx_data}, 32'h00);
      chk("ignored_frame_active", {31'd0, bus.frame_active}, 32'd0);
      chk("ignored_miso", {31'd0, bus.miso}, 32'd1);
      bus.ss = 1'b1;
      wait_clk(6);
      bus.ss = 1'b0;
      wait_clk(4);
      spi_byte(8'hC3, 4, 8, m1);
      bus.ss = 1'b1;
      wait_clk(6);
      chk("after_rst_done_cnt", done_cnt - base, 32'd1);
      chk("after_rst_rx_data", {24'd0, bus.rx_data}, 32'hC3);
      chk("after_rst_miso", {24'd0, m1}, 32'h96);

      // Deselected: sclk toggling must leave miso high and give no strobe
      base = done_cnt;
      for (int i = 0; i < 8; i++) begin
         bus.mosi = 1'($urandom_range(1, 0));
         wait_clk(4);
         bus.sclk = 1'b1;
         wait_clk(2);
         chk("desel_miso", {31'd0, bus.miso}, 32'd1);
         wait_clk(2);
         bus.sclk = 1'b0;
      end
      wait_clk(6);
      chk("desel_no_done", done_cnt - base, 32'd0);

      // Boundary rate: sclk at exactly clk/4
      base = done_cnt;
      bus.ss = 1'b0;
      wait_clk(4);
      spi_byte(8'h7E, 2, 8, m1);
      bus.ss = 1'b1;
      wait_clk(6);
      chk("fast_done_cnt", done_cnt - base, 32'd1);
      chk("fast_rx_data", {24'd0, bus.rx_data}, 32'h7E);
      chk("no_double_strobe", dbl_cnt, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
